jt1942_objbuf: RTL and testbench

Ping-pong object line buffer for the 1942 object pipeline. It receives object pixels from the object draw engine while the current line's objects are being scanned. In the same line it plays the previous line's pixels back to the colour mixer, indexed by horizontal position. Each location is cleared to transparent right after it is displayed. Buffer halves swap on the `line` toggle produced by the object timing block.

---
 rtl/jt1942_objbuf_if.sv | 26 ++
 rtl/jt1942_objbuf.sv | 163 ++++++++++++++++
 tb/tb_jt1942_objbuf.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jt1942_objbuf_if.sv
// Object line buffer bus: pixel-rate enable, buffer select, display read
// position and draw requests from the object pipeline, plus the pixel and
// busy indication returned by the buffer.
//   master : object timing / draw engine side (drives cen6, line, H, vis, wr_*)
//   slave  : line buffer side (drives obj_pxl, busy)
interface jt1942_objbuf_if;
  logic       cen6;     // 6 MHz clock enable
  logic       line;     // draw half = line, display half = ~line
  logic [8:0] H;        // horizontal counter, H[7:0] is the display address
  logic       vis;      // display read/clear window
  logic       wr_en;    // draw request
  logic [7:0] wr_pos;   // draw x position
  logic [7:0] wr_pxl;   // {palette, colour}
  logic [7:0] obj_pxl;  // displayed pixel, 8'hFF = transparent
  logic       busy;     // post-reset clear sweep running

  modport master (
    output cen6, line, H, vis, wr_en, wr_pos, wr_pxl,
    input  obj_pxl, busy
  );

  modport slave (
    input  cen6, line, H, vis, wr_en, wr_pos, wr_pxl,
    output obj_pxl, busy
  );
endinterface

// File: rtl/jt1942_objbuf.sv
// Ping-pong object line buffer. The draw engine writes the current line into
// half 'line' through a two-step read-modify-write while the display plays the
// previous line back from half '~line', clearing each byte once shown.
// After reset both halves are swept to 8'hFF, one address per clk.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - jt1942_objbuf_if.slave (cen6, line, H, vis, wr_*, obj_pxl, busy)
//
// Build option: define JT1942_OBJBUF_PRIO_EN to keep the first-drawn object
// (commit only over a transparent stored colour); otherwise the last-drawn
// object wins.
module jt1942_objbuf #(
  parameter logic [3:0] TRANSP = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  jt1942_objbuf_if.slave     bus
);

  localparam logic [7:0] ClrByte = 8'hFF;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  // Clear sweep
  logic       busy_q;
  logic [7:0] clr_addr_q;

  // Draw stage 1: latched request plus the byte currently stored at wr_pos.
  // The commit (stage 2) happens on the following cen6 from these registers.
  logic       s1_vld_q;
  logic       s1_half_q;
  logic [7:0] s1_pos_q;
  logic [7:0] s1_pxl_q;
  logic [7:0] s1_rd_q;

  // Display path: read at one cen6, present and clear at the next
  logic       rd_vld_q;
  logic       rd_half_q;
  logic [7:0] rd_addr_q;
  logic [7:0] rd_data_q;
  logic [7:0] obj_pxl_q;

  logic       run;
  logic       commit;
  logic       fwd;
  logic [7:0] draw_rd;
  logic [7:0] disp_rd;
  logic [7:0] s1_rd_d;

  logic       we_a, we_b;
  logic [7:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;

  logic       unused_h8;
  assign unused_h8 = bus.H[8];

  assign run = bus.cen6 && !busy_q;

`ifdef JT1942_OBJBUF_PRIO_EN
  assign commit = s1_vld_q && (s1_rd_q[3:0] == TRANSP);
`else
  logic unused_s1_rd;
  assign unused_s1_rd = ^s1_rd_q;
  assign commit       = s1_vld_q;
`endif

  // Draw and display always address opposite halves, so each RAM sees at
  // most one read per cycle.
  assign draw_rd = bus.line ? mem_b[bus.wr_pos] : mem_a[bus.wr_pos];
  assign disp_rd = bus.line ? mem_a[bus.H[7:0]] : mem_b[bus.H[7:0]];

  // A commit landing on the byte being read this cycle must be seen by the
  // new request, otherwise back-to-back draws to one pixel would race.
  assign fwd     = commit && (s1_half_q == bus.line) && (s1_pos_q == bus.wr_pos);
  assign s1_rd_d = fwd ? s1_pxl_q : draw_rd;

  // Write ports. The commit half and the clear half were both latched on the
  // same cen6 from line and its inverse, so they never target the same RAM.
  always_comb begin
    we_a   = 1'b0;
    we_b   = 1'b0;
    addr_a = 8'd0;
    addr_b = 8'd0;
    din_a  = ClrByte;
    din_b  = ClrByte;
    if (!rst) begin
      if (busy_q) begin
        we_a   = 1'b1;
        we_b   = 1'b1;
        addr_a = clr_addr_q;
        addr_b = clr_addr_q;
      end else if (bus.cen6) begin
        if (commit) begin
          if (s1_half_q) begin
            we_b   = 1'b1;
            addr_b = s1_pos_q;
            din_b  = s1_pxl_q;
          end else begin
            we_a   = 1'b1;
            addr_a = s1_pos_q;
            din_a  = s1_pxl_q;
          end
        end
        if (rd_vld_q) begin
          if (rd_half_q) begin
            we_b   = 1'b1;
            addr_b = rd_addr_q;
            din_b  = ClrByte;
          end else begin
            we_a   = 1'b1;
            addr_a = rd_addr_q;
            din_a  = ClrByte;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= din_a;
    if (we_b) mem_b[addr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b1;
      clr_addr_q <= 8'd0;
      s1_vld_q   <= 1'b0;
      s1_half_q  <= 1'b0;
      s1_pos_q   <= 8'd0;
      s1_pxl_q   <= ClrByte;
      s1_rd_q    <= ClrByte;
      rd_vld_q   <= 1'b0;
      rd_half_q  <= 1'b0;
      rd_addr_q  <= 8'd0;
      rd_data_q  <= ClrByte;
      obj_pxl_q  <= ClrByte;
    end else if (busy_q) begin
      clr_addr_q <= clr_addr_q + 8'd1;
      if (clr_addr_q == 8'hFF) busy_q <= 1'b0;
    end else if (run) begin
      // Transparent requests are dropped here and never reach the commit
      s1_vld_q  <= bus.wr_en && (bus.wr_pxl[3:0] != TRANSP);
      s1_half_q <= bus.line;
      s1_pos_q  <= bus.wr_pos;
      s1_pxl_q  <= bus.wr_pxl;
      s1_rd_q   <= s1_rd_d;

      rd_vld_q  <= bus.vis;
      rd_half_q <= ~bus.line;
      rd_addr_q <= bus.H[7:0];
      rd_data_q <= disp_rd;
      obj_pxl_q <= rd_vld_q ? rd_data_q : ClrByte;
    end
  end

  assign bus.obj_pxl = obj_pxl_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_jt1942_objbuf.sv
// Bench for jt1942_objbuf: directed test-plan sequences plus random traffic,
// checked against a per-cen6 reference model of the two line halves.
module tb_jt1942_objbuf;

  logic clk;
  logic rst;

  jt1942_objbuf_if bus ();

  jt1942_objbuf #(
    .TRANSP (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef JT1942_OBJBUF_PRIO_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  // Reference model: two 256-byte halves. Reads at a cen6 see memory as it was
  // before that cen6; draw commits and display clears land one cen6 later.
  logic [7:0] m_mem [2][256];
  logic [7:0] m_out;
  logic       pw_vld, pw_half;
  logic [7:0] pw_pos, pw_pxl;
  logic       pc_vld, pc_half;
  logic [7:0] pc_addr;

  logic cur_line;
  logic last_vis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < 2; h++)
      for (int a = 0; a < 256; a++) m_mem[h][a] = 8'hFF;
    m_out  = 8'hFF;
    pw_vld = 1'b0;
    pc_vld = 1'b0;
  endtask

  task automatic model_tick(input logic l, input logic [7:0] h, input logic v,
                            input logic we, input logic [7:0] wp, input logic [7:0] wx,
                            output logic [7:0] e);
    logic [7:0] rd;
    e  = m_out;
    rd = v ? m_mem[l ? 0 : 1][h] : 8'hFF;
    if (pw_vld && (!Prio || m_mem[pw_half][pw_pos][3:0] == 4'hF))
      m_mem[pw_half][pw_pos] = pw_pxl;
    if (pc_vld) m_mem[pc_half][pc_addr] = 8'hFF;
    pc_vld  = v;
    pc_half = ~l;
    pc_addr = h;
    pw_vld  = we && (wx[3:0] != 4'hF);
    pw_half = l;
    pw_pos  = wp;
    pw_pxl  = wx;
    m_out   = rd;
  endtask

  task automatic tick(input logic l, input logic [8:0] h, input logic v,
                      input logic we, input logic [7:0] wp, input logic [7:0] wx);
    logic [7:0] e;
    @(negedge clk);
    bus.line   = l;
    bus.H      = h;
    bus.vis    = v;
    bus.wr_en  = we;
    bus.wr_pos = wp;
    bus.wr_pxl = wx;
    bus.cen6   = 1'b1;
    model_tick(l, h[7:0], v, we, wp, wx, e);
    exp_q.push_back(e);
    cur_line = l;
    last_vis = v;
    @(negedge clk);
    bus.cen6 = 1'b0;
  endtask

  task automatic idle(input logic l);
    tick(l, 9'd0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    int cycles;
    @(negedge clk);
    bus.cen6  = 1'b0;
    bus.wr_en = 1'b0;
    bus.vis   = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd1);
    check("rst_obj_pxl", {24'd0, bus.obj_pxl}, 32'hFF);
    rst = 1'b0;
    model_reset();
    cycles = 0;
    while (bus.busy && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (bus.busy) check("busy_obj_pxl", {24'd0, bus.obj_pxl}, 32'hFF);
    end
    check("sweep_len", cycles, 32'd256);
    last_vis = 1'b0;
  endtask

  task automatic full_line_read(input logic l);
    for (int h = 0; h < 256; h++) tick(l, 9'(h), 1'b1, 1'b0, 8'd0, 8'd0);
    idle(l);
  endtask

  // Monitor: obj_pxl updates once per cen6; compare against the scoreboard.
  always @(posedge clk) begin
    if (bus.cen6 && !rst) begin
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: no expected value queued, got %h", bus.obj_pxl);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.obj_pxl !== mon_exp) begin
          n_bad++;
          $display("FAIL obj_pxl: got %h, expected %h", bus.obj_pxl, mon_exp);
        end
      end
    end
  end

  initial begin
    logic       l, v, we;
    logic [8:0] h;
    logic [7:0] wp, wx;

    rst        = 1'b1;
    bus.cen6   = 1'b0;
    bus.line   = 1'b0;
    bus.H      = 9'd0;
    bus.vis    = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_pos = 8'd0;
    bus.wr_pxl = 8'd0;
    cur_line   = 1'b0;
    last_vis   = 1'b0;
    model_reset();

    do_reset();
    full_line_read(1'b0);

    // Single draw, then the cleared location on the next display of that half
    tick(1'b0, 9'd0, 1'b0, 1'b1, 8'd10, 8'h35);
    idle(1'b0);
    tick(1'b1, 9'd10, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    check("single_draw", {24'd0, bus.obj_pxl}, 32'h35);
    idle(1'b0);
    idle(1'b1);
    tick(1'b1, 9'd10, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    check("cleared_after_display", {24'd0, bus.obj_pxl}, 32'hFF);

    // Back-to-back draws to one pixel
    tick(1'b0, 9'd0, 1'b0, 1'b1, 8'd20, 8'h12);
    tick(1'b0, 9'd0, 1'b0, 1'b1, 8'd20, 8'h47);
    idle(1'b0);
    idle(1'b1);
    tick(1'b1, 9'd20, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    check("priority", {24'd0, bus.obj_pxl}, Prio ? 32'h12 : 32'h47);

    // Transparent request dropped
    tick(1'b0, 9'd0, 1'b0, 1'b1, 8'd30, 8'h21);
    tick(1'b0, 9'd0, 1'b0, 1'b1, 8'd30, 8'h5F);
    idle(1'b0);
    idle(1'b1);
    tick(1'b1, 9'd30, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    check("transparent_drop", {24'd0, bus.obj_pxl}, 32'h21);

    // Write on the cen6 just before the swap lands in the old draw half
    tick(1'b0, 9'd0, 1'b0, 1'b1, 8'd40, 8'h66);
    tick(1'b1, 9'd100, 1'b0, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    tick(1'b1, 9'd40, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    check("swap_race", {24'd0, bus.obj_pxl}, 32'h66);

    // vis=0 neither shows nor clears
    tick(1'b0, 9'd0, 1'b0, 1'b1, 8'd50, 8'h77);
    idle(1'b0);
    idle(1'b1);
    tick(1'b1, 9'd50, 1'b0, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    check("vis0_hidden", {24'd0, bus.obj_pxl}, 32'hFF);
    tick(1'b1, 9'd50, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1'b1);
    check("vis0_not_cleared", {24'd0, bus.obj_pxl}, 32'h77);

    // Random traffic; line only toggles after a cen6 with vis=0
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        tick(cur_line, 9'd0, 1'b0, 1'b1, 8'd5, 8'h9A);
        do_reset();
        full_line_read(cur_line);
      end
      l  = (!last_vis && ($urandom_range(0, 5) == 0)) ? ~cur_line : cur_line;
      v  = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 2) == 0) ? 9'($urandom_range(0, 511))
                                       : 9'($urandom_range(0, 15));
      we = $urandom_range(0, 1) == 1;
      wp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 15));
      wx = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) wx[3:0] = 4'hF;
      tick(l, h, v, we, wp, wx);
    end
    idle(cur_line);
    idle(cur_line);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
